rtp_packetizer: RTL
===================

# rtp_packetizer

Multi-channel RTP audio packetizer that replaces the fixed-width single-buffer packer in the ethernet audio path. It accepts one PCM frame per beat (all channels), fills ping-pong packet buffers and streams each completed RTP packet (12-byte header plus big-endian payload) to the UDP transmit engine as a byte stream with valid/ready. It adds configurable payload type, sequence-number seeding, frame-accurate timestamps, overflow dropping with a counter, and an optional marker bit.

## Interface
- SAMPLE_W, 16: bits per sample; one of 8/16/24/32.
- CHANNELS, 2: channels per frame; range 1..8.
- FRAMES, 120: frames per packet; payload bytes P = FRAMES*CHANNELS*SAMPLE_W/8; 12+P ≤ 1472.
- PT, 7'd10: RTP payload type.
- SSRC, 32'h12345678: RTP synchronisation source.
- SEQ_INIT, 16'h0000: sequence number of the first packet after reset.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  one frame present; no backpressure to the audio source.
- s_data  in  CHANNELS*SAMPLE_W  frame; channel 0 in the MSBs.
- m_valid  out  1  byte valid toward the UDP engine.
- m_ready  in  1  UDP engine accepts the byte.
- m_data  out  8  packet byte, network order.
- m_last  out  1  final byte of the packet.
- m_length  out  16  constant 12+P; sampled by the UDP engine at the first byte.
- drop_cnt  out  16  frames dropped, saturating at 16'hFFFF.

## Operation
- Two buffers, B0 and B1, each holding FRAMES frames, with flags full0/full1. The writer starts on B0 and alternates.
- Write: on s_valid, if the write buffer is not full, the frame is stored at wr_idx and wr_idx increments. When wr_idx reaches FRAMES-1, the buffer is marked full with its header fields (seq, ts, M) latched, and the writer switches buffers with wr_idx=0.
- Drop: on s_valid, if the write buffer is full, the frame is discarded and drop_cnt increments. frame_ctr still advances.
- Timestamp: frame_ctr (32 bits) counts every s_valid beat, stored or dropped. A packet's ts equals frame_ctr at its first stored frame. It wraps modulo 2^32.
- Sequence: seq increments by 1 per packet latched, wrapping 16'hFFFF→0.
- Reader FSM:
  - IDLE → HDR when the read buffer is full.
  - HDR emits 12 bytes: 8'h80, {M,PT}, seq[15:8], seq[7:0], ts MSB-first, SSRC MSB-first.
  - HDR → PAY after byte 11.
  - PAY emits frames in order, channel 0 first, each sample MSB-byte first.
  - After the last payload byte: clear the full flag, switch read buffer, go to IDLE.
- Simultaneous events:
  - If the writer fills a buffer in the same cycle the reader frees the other, no drop occurs.
  - A frame arriving in the cycle the reader clears a flag uses the pre-clear state; that frame is dropped only if its target buffer was full before the edge.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_last=0, drop_cnt=0.
  - seq=SEQ_INIT, frame_ctr=0, wr_idx=0.
  - Both flags clear; writer and reader on B0; FSM IDLE.
  - m_length is always 12+P.
- Reset mid-packet abandons the packet immediately: m_valid=0 the next cycle and all buffer contents are discarded.
- Latency: m_valid rises 2 cycles after the clock edge that stores the final frame, when the reader is idle.
- Handshake:
  - A byte transfers when m_valid&&m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable.
  - m_valid is never deasserted mid-packet.
- Full throughput: one byte per cycle under continuous m_ready, with 1 idle cycle between packets.
- m_last is high only together with byte 12+P-1.

## Configuration
- RTP_MARKER_EN defined:
  - M=1 on the first packet after reset.
  - M=1 on the first packet started after any dropped frame. A drop sets a sticky flag that is cleared when the next packet's header is latched.
- RTP_MARKER_EN undefined: M is always 0, and the sticky flag logic is absent.

## Test plan
All scenarios use SAMPLE_W=16, CHANNELS=2, FRAMES=4, SEQ_INIT=0, RTP_MARKER_EN defined, unless stated.
- Single packet: feed 4 frames 32'h0001_0002 … 32'h0007_0008 with m_ready=1. Expect 28 bytes 80 8A 00 00 00 00 00 00 12 34 56 78 00 01 00 02 … 00 08, with m_last on byte 27.
- Backpressure: drive m_ready with a random 50% pattern. Expect an identical byte sequence, m_data held stable while stalled, and no duplicated or lost bytes.
- Overflow: hold m_ready=0 and feed 12 frames. Expect drop_cnt=4 and two packets, seq 0 and 1, with ts 0 and 4. Then release m_ready and feed 4 frames: the third packet has ts=12, seq=2 and byte1=8'h8A.
- Sequence wrap: set SEQ_INIT=16'hFFFF and send 2 packets. Expect seq bytes FF FF, then 00 00.
- Reset mid-packet: assert rst_n=0 at byte 15. Expect m_valid=0 the next cycle. After release, the next packet starts with seq=0 and ts=0.
- Width corner: SAMPLE_W=24, CHANNELS=1, FRAMES=2, frames 24'hABCDEF and 24'h123456. Expect m_length=18 and payload AB CD EF 12 34 56.

Source files
------------

// File: rtl/rtp_packetizer.sv
`timescale 1ns/1ps
// Ping-pong RTP audio packetizer: stores PCM frames and streams 12-byte header + big-endian payload.
// Define RTP_MARKER_EN to drive the RTP marker bit (first packet after reset or after any drop).
module rtp_packetizer #(
    parameter int          SAMPLE_W = 16,
    parameter int          CHANNELS = 2,
    parameter int          FRAMES   = 120,
    parameter logic [6:0]  PT       = 7'd10,
    parameter logic [31:0] SSRC     = 32'h12345678,
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [7:0]                   m_data,
    output logic                         m_last,
    output logic [15:0]                  m_length,
    output logic [15:0]                  drop_cnt
);
    localparam int FW     = CHANNELS * SAMPLE_W;
    localparam int BPF    = FW / 8;
    localparam int P      = FRAMES * BPF;
    localparam int IDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int BIDX_W = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAMES - 1);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BPF - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    // Writer side
    logic              wr_buf_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [1:0]        full_q, full_d;
    logic [31:0]       frame_ctr_q;
    logic [15:0]       seq_q;
    logic [15:0]       drop_cnt_q;
    logic              do_store, do_drop, wr_last, marker;

    // Buffer storage and per-buffer latched header fields
    logic [FW-1:0]     mem_q [2][FRAMES];
    logic [31:0]       hdr_ts_q [2];
    logic [15:0]       hdr_seq_q [2];
    logic [1:0]        hdr_m_q;

    // Reader side
    state_t            state_q, state_d;
    logic              rd_buf_q, rd_buf_d;
    logic [3:0]        hcnt_q, hcnt_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic              m_valid_q, m_valid_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              clr_full, load;
    logic [7:0]        hdr_byte, pay_byte;
    logic [FW-1:0]     rd_frame;
    logic [15:0]       rd_seq;
    logic [31:0]       rd_ts;

    assign do_store = s_valid && !full_q[wr_buf_q];
    assign do_drop  = s_valid &&  full_q[wr_buf_q];
    assign wr_last  = (wr_idx_q == LAST_IDX);

`ifdef RTP_MARKER_EN
    logic sticky_q;

    // Set out of reset so the very first packet is marked.
    always_ff @(posedge clk) begin
        if (!rst_n)                   sticky_q <= 1'b1;
        else if (do_store && wr_last) sticky_q <= 1'b0;
        else if (do_drop)             sticky_q <= 1'b1;
    end
    assign marker = sticky_q;
`else
    assign marker = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_buf_q    <= 1'b0;
            wr_idx_q    <= '0;
            frame_ctr_q <= 32'd0;
            seq_q       <= SEQ_INIT;
            drop_cnt_q  <= 16'd0;
            full_q      <= 2'b00;
        end else begin
            full_q <= full_d;
            if (s_valid) frame_ctr_q <= frame_ctr_q + 32'd1;
            if (do_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (do_store) begin
                if (wr_last) begin
                    wr_idx_q <= '0;
                    wr_buf_q <= ~wr_buf_q;
                    seq_q    <= seq_q + 16'd1;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end
        end
    end

    // NOTE: buffer storage carries no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_q[wr_buf_q][wr_idx_q] <= s_data;
            if (wr_idx_q == '0) hdr_ts_q[wr_buf_q] <= frame_ctr_q;
            if (wr_last) begin
                hdr_seq_q[wr_buf_q] <= seq_q;
                hdr_m_q[wr_buf_q]   <= marker;
            end
        end
    end

    // Writer and reader never target the same flag in one cycle.
    always_comb begin
        full_d = full_q;
        if (clr_full)            full_d[rd_buf_q] = 1'b0;
        if (do_store && wr_last) full_d[wr_buf_q] = 1'b1;
    end

    assign rd_frame = mem_q[rd_buf_q][fidx_q];
    assign rd_seq   = hdr_seq_q[rd_buf_q];
    assign rd_ts    = hdr_ts_q[rd_buf_q];
    assign pay_byte = 8'(rd_frame >> (8 * (BPF - 1 - int'(bidx_q))));

    always_comb begin
        hdr_byte = 8'h00;
        case (hcnt_q)
            4'd0:    hdr_byte = 8'h80;
            4'd1:    hdr_byte = {hdr_m_q[rd_buf_q], PT};
            4'd2:    hdr_byte = rd_seq[15:8];
            4'd3:    hdr_byte = rd_seq[7:0];
            4'd4:    hdr_byte = rd_ts[31:24];
            4'd5:    hdr_byte = rd_ts[23:16];
            4'd6:    hdr_byte = rd_ts[15:8];
            4'd7:    hdr_byte = rd_ts[7:0];
            4'd8:    hdr_byte = SSRC[31:24];
            4'd9:    hdr_byte = SSRC[23:16];
            4'd10:   hdr_byte = SSRC[15:8];
            4'd11:   hdr_byte = SSRC[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // The output byte register reloads only when empty or being consumed.
    assign load = !m_valid_q || m_ready;

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rd_buf_d  = rd_buf_q;
        hcnt_d    = hcnt_q;
        fidx_d    = fidx_q;
        bidx_d    = bidx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        clr_full  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if (full_q[rd_buf_q]) begin
                    state_d = HDR;
                    hcnt_d  = 4'd0;
                end
            end
            HDR: begin
                if (load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = hdr_byte;
                    m_last_d  = 1'b0;
                    hcnt_d    = hcnt_q + 4'd1;
                    if (hcnt_q == 4'd11) begin
                        state_d = PAY;
                        fidx_d  = '0;
                        bidx_d  = '0;
                    end
                end
            end
            PAY: begin
                if (load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = pay_byte;
                    m_last_d  = 1'b0;
                    if (bidx_q == LAST_BIDX) begin
                        bidx_d = '0;
                        fidx_d = fidx_q + 1'b1;
                        if (fidx_q == LAST_IDX) begin
                            m_last_d = 1'b1;
                            clr_full = 1'b1;
                            rd_buf_d = ~rd_buf_q;
                            state_d  = IDLE;
                        end
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_buf_q  <= 1'b0;
            hcnt_q    <= 4'd0;
            fidx_q    <= '0;
            bidx_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_buf_q  <= rd_buf_d;
            hcnt_q    <= hcnt_d;
            fidx_q    <= fidx_d;
            bidx_q    <= bidx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign m_length = 16'(12 + P);
    assign drop_cnt = drop_cnt_q;

endmodule
